cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
Main control-unit finite state machine (FSM) for the simple microprocessor. It sequences every instruction through fetch, decode and execute. It drives the one-hot control strobes for the program counter (PC), instruction register (IR), register file, arithmetic logic unit (ALU) and RAM. Opcode comes from the IR's opcode field; all outputs feed the datapath directly.

Parameters:
OPCODE_WIDTH, 3, width of the Opcode input.
NUM_STATES, 3, cycles per instruction after reset (FETCH, DECODE, EXECUTE); informational, fixed by the FSM.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-low reset (0 = reset); sampled on rising Clk.
Opcode  input  OPCODE_WIDTH  opcode field of the current IR contents.
PC_Clr  output  1  clear PC to 0.
PC_Load  output  1  load PC from IR Dest_Reg field (jump).
PC_Inc  output  1  PC <= PC+1.
IR_Load  output  1  latch instruction word from RAM into IR.
Reg_Load  output  1  write Reg_Data_In into Dest_Reg.
Alu_Add  output  1  ALU adds its operands.
Alu_Sub  output  1  ALU subtracts (op1 - op2).
Alu_Mul  output  1  ALU multiplies its operands.
Alu_Pass  output  1  ALU passes operand 1 to its output.
Ram_Data_Read  output  1  RAM data read.
Ram_Data_Write  output  1  RAM data write.
Ram_Inst_Read  output  1  RAM instruction read at PC.
Load_M  output  1  Source_Reg1 drives the RAM address.
Load_I  output  1  Source_Reg1 (immediate) drives Reg_Data_In.

Behaviour:
- States: RESET, FETCH, DECODE, EXECUTE; 2-bit state register.
- Reset==0 at a rising edge: state <= RESET, regardless of current state. A mid-instruction reset aborts the instruction; no partial writes happen after that edge.
- Transitions with Reset==1: RESET->FETCH; FETCH->DECODE; DECODE->EXECUTE; EXECUTE->FETCH.
- Outputs are combinational from state and Opcode. Every output not listed for a state/opcode is 0.
- RESET: PC_Clr=1.
- FETCH: Ram_Inst_Read=1, IR_Load=1.
- DECODE: PC_Inc=1.
- EXECUTE, by Opcode:
  - 000 NOP: no outputs.
  - 001 LOAD_M: Load_M=1, Ram_Data_Read=1, Reg_Load=1.
  - 010 LOAD_I: Load_I=1, Reg_Load=1.
  - 011 STORE: Load_M=1, Alu_Pass=1, Ram_Data_Write=1.
  - 100 ADD: Alu_Add=1, Reg_Load=1.
  - 101 SUB: Alu_Sub=1, Reg_Load=1.
  - 110 MUL: Alu_Mul=1, Reg_Load=1.
  - 111 JMP: PC_Load=1.
- If OPCODE_WIDTH>3, only the low 3 bits are decoded. Any X/undefined opcode decodes as NOP.
- Invariants:
  - At most one ALU strobe is active at a time.
  - Ram_Data_Read and Ram_Data_Write are never both 1.
  - PC_Clr appears only in RESET.
  - PC_Inc and PC_Load are never in the same cycle.
- Instruction latency: 3 cycles per instruction. The first FETCH is 1 cycle after reset deasserts.
- The state register initialises to RESET (power-on/simulation default) so outputs are defined before the first reset edge.
- Opcode changes outside EXECUTE have no effect on outputs.

Test Plan:
1. Hold Reset=0 for 2 edges -> PC_Clr=1, all other outputs 0. Release Reset=1 -> next cycle FETCH: Ram_Inst_Read=1, IR_Load=1, PC_Clr=0.
2. Opcode=010 after FETCH -> DECODE: PC_Inc=1. EXECUTE: Load_I=1, Reg_Load=1. Following cycle returns to FETCH.
3. Sweep Opcode 000..111, one instruction each -> EXECUTE outputs exactly match the opcode table; FETCH/DECODE outputs identical for every opcode.
4. Opcode=111 -> EXECUTE: PC_Load=1, PC_Inc=0, Reg_Load=0. Next cycle FETCH.
5. Opcode=011 -> EXECUTE: Load_M=1, Alu_Pass=1, Ram_Data_Write=1, Ram_Data_Read=0, Reg_Load=0.
6. Drive Reset=0 during DECODE, then during EXECUTE of ADD -> next edge enters RESET (PC_Clr=1, Alu_Add=0). After release, resumes at FETCH.

Source files
------------

// File: rtl/cpu_controller.sv
// Control-unit FSM for the simple microprocessor: sequences each instruction
// through FETCH, DECODE and EXECUTE and decodes the datapath control strobes.
module cpu_controller #(
    parameter int OPCODE_WIDTH = 3,
    parameter int NUM_STATES   = 3
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    output logic                    PC_Clr,
    output logic                    PC_Load,
    output logic                    PC_Inc,
    output logic                    IR_Load,
    output logic                    Reg_Load,
    output logic                    Alu_Add,
    output logic                    Alu_Sub,
    output logic                    Alu_Mul,
    output logic                    Alu_Pass,
    output logic                    Ram_Data_Read,
    output logic                    Ram_Data_Write,
    output logic                    Ram_Inst_Read,
    output logic                    Load_M,
    output logic                    Load_I
);

    // One extra encoding beyond the instruction cycles is needed for RESET.
    localparam int STATE_W = $clog2(NUM_STATES + 1);

    typedef enum logic [STATE_W-1:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE
    } state_t;

    // Power-on value keeps the strobes defined before the first reset edge.
    state_t state = ST_RESET;

    logic [2:0] op;
    assign op = Opcode[2:0];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_RESET;
        end else begin
            case (state)
                ST_RESET:   state <= ST_FETCH;
                ST_FETCH:   state <= ST_DECODE;
                ST_DECODE:  state <= ST_EXECUTE;
                ST_EXECUTE: state <= ST_FETCH;
                default:    state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        PC_Clr         = 1'b0;
        PC_Load        = 1'b0;
        PC_Inc         = 1'b0;
        IR_Load        = 1'b0;
        Reg_Load       = 1'b0;
        Alu_Add        = 1'b0;
        Alu_Sub        = 1'b0;
        Alu_Mul        = 1'b0;
        Alu_Pass       = 1'b0;
        Ram_Data_Read  = 1'b0;
        Ram_Data_Write = 1'b0;
        Ram_Inst_Read  = 1'b0;
        Load_M         = 1'b0;
        Load_I         = 1'b0;
        case (state)
            ST_RESET: PC_Clr = 1'b1;
            ST_FETCH: begin
                Ram_Inst_Read = 1'b1;
                IR_Load       = 1'b1;
            end
            ST_DECODE: PC_Inc = 1'b1;
            ST_EXECUTE: begin
                // Unknown opcodes fall through to default and behave as NOP.
                case (op)
                    3'b001: begin
                        Load_M        = 1'b1;
                        Ram_Data_Read = 1'b1;
                        Reg_Load      = 1'b1;
                    end
                    3'b010: begin
                        Load_I   = 1'b1;
                        Reg_Load = 1'b1;
                    end
                    3'b011: begin
                        Load_M         = 1'b1;
                        Alu_Pass       = 1'b1;
                        Ram_Data_Write = 1'b1;
                    end
                    3'b100: begin
                        Alu_Add  = 1'b1;
                        Reg_Load = 1'b1;
                    end
                    3'b101: begin
                        Alu_Sub  = 1'b1;
                        Reg_Load = 1'b1;
                    end
                    3'b110: begin
                        Alu_Mul  = 1'b1;
                        Reg_Load = 1'b1;
                    end
                    3'b111:  PC_Load = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed vector table, opcode sweep and
// randomized run compared against a cycle-count reference model.
module tb_cpu_controller;

    logic       Clk;
    logic       Reset;
    logic [2:0] Opcode;
    logic PC_Clr, PC_Load, PC_Inc, IR_Load, Reg_Load;
    logic Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass;
    logic Ram_Data_Read, Ram_Data_Write, Ram_Inst_Read, Load_M, Load_I;

    cpu_controller #(.OPCODE_WIDTH(3), .NUM_STATES(3)) dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode),
        .PC_Clr(PC_Clr), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .IR_Load(IR_Load), .Reg_Load(Reg_Load),
        .Alu_Add(Alu_Add), .Alu_Sub(Alu_Sub), .Alu_Mul(Alu_Mul),
        .Alu_Pass(Alu_Pass), .Ram_Data_Read(Ram_Data_Read),
        .Ram_Data_Write(Ram_Data_Write), .Ram_Inst_Read(Ram_Inst_Read),
        .Load_M(Load_M), .Load_I(Load_I)
    );

    localparam logic [13:0] M_PC_CLR = 14'h2000;
    localparam logic [13:0] M_PC_LD  = 14'h1000;
    localparam logic [13:0] M_PC_INC = 14'h0800;
    localparam logic [13:0] M_IR_LD  = 14'h0400;
    localparam logic [13:0] M_REG_LD = 14'h0200;
    localparam logic [13:0] M_ADD    = 14'h0100;
    localparam logic [13:0] M_SUB    = 14'h0080;
    localparam logic [13:0] M_MUL    = 14'h0040;
    localparam logic [13:0] M_PASS   = 14'h0020;
    localparam logic [13:0] M_RD     = 14'h0010;
    localparam logic [13:0] M_WR     = 14'h0008;
    localparam logic [13:0] M_IRD    = 14'h0004;
    localparam logic [13:0] M_LM     = 14'h0002;
    localparam logic [13:0] M_LI     = 14'h0001;

    localparam logic [13:0] E_RESET  = M_PC_CLR;
    localparam logic [13:0] E_FETCH  = M_IRD | M_IR_LD;
    localparam logic [13:0] E_DECODE = M_PC_INC;

    logic [13:0] outs;
    assign outs = {PC_Clr, PC_Load, PC_Inc, IR_Load, Reg_Load, Alu_Add, Alu_Sub,
                   Alu_Mul, Alu_Pass, Ram_Data_Read, Ram_Data_Write,
                   Ram_Inst_Read, Load_M, Load_I};

    typedef struct {
        logic        rst;
        logic [2:0]  opc;
        logic [13:0] exp;
    } vec_t;

    vec_t        tbl[19];
    logic [13:0] exec_tbl[8];
    int          checks   = 0;
    int          failures = 0;
    int          since    = -1;  // cycles since reset released; -1 while in reset

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] model_exp(input int s, input logic [2:0] opc);
        if (s < 0)        return E_RESET;
        if (s % 3 == 0)   return E_FETCH;
        if (s % 3 == 1)   return E_DECODE;
        return exec_tbl[opc];
    endfunction

    // Apply inputs, clock once, then advance the reference model.
    task automatic step(input logic rst, input logic [2:0] opc);
        Reset  = rst;
        Opcode = opc;
        @(posedge Clk);
        #1;
        if (!rst) since = -1;
        else      since = since + 1;
    endtask

    initial begin
        logic [2:0] r_opc;
        logic       r_rst;

        exec_tbl[0] = 14'h0;
        exec_tbl[1] = M_LM | M_RD | M_REG_LD;
        exec_tbl[2] = M_LI | M_REG_LD;
        exec_tbl[3] = M_LM | M_PASS | M_WR;
        exec_tbl[4] = M_ADD | M_REG_LD;
        exec_tbl[5] = M_SUB | M_REG_LD;
        exec_tbl[6] = M_MUL | M_REG_LD;
        exec_tbl[7] = M_PC_LD;

        tbl[0]  = '{1'b0, 3'd0, E_RESET};
        tbl[1]  = '{1'b0, 3'd5, E_RESET};
        tbl[2]  = '{1'b1, 3'd2, E_FETCH};
        tbl[3]  = '{1'b1, 3'd2, E_DECODE};
        tbl[4]  = '{1'b1, 3'd2, M_LI | M_REG_LD};
        tbl[5]  = '{1'b1, 3'd7, E_FETCH};
        tbl[6]  = '{1'b1, 3'd7, E_DECODE};
        tbl[7]  = '{1'b1, 3'd7, M_PC_LD};
        tbl[8]  = '{1'b1, 3'd3, E_FETCH};
        tbl[9]  = '{1'b1, 3'd3, E_DECODE};
        tbl[10] = '{1'b1, 3'd3, M_LM | M_PASS | M_WR};
        tbl[11] = '{1'b1, 3'd4, E_FETCH};
        tbl[12] = '{1'b1, 3'd4, E_DECODE};
        tbl[13] = '{1'b0, 3'd4, E_RESET};
        tbl[14] = '{1'b1, 3'd4, E_FETCH};
        tbl[15] = '{1'b1, 3'd4, E_DECODE};
        tbl[16] = '{1'b1, 3'd4, M_ADD | M_REG_LD};
        tbl[17] = '{1'b0, 3'd4, E_RESET};
        tbl[18] = '{1'b1, 3'd4, E_FETCH};

        Reset  = 1'b0;
        Opcode = 3'd0;
        #1;
        chk("power_on", outs, E_RESET);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].opc);
            chk($sformatf("vec%0d", i), outs, tbl[i].exp);
        end

        // Reset asserted during EXECUTE: strobes stay on until the edge.
        step(1'b1, 3'd4);
        step(1'b1, 3'd4);
        Reset = 1'b0;
        #1;
        chk("exec_hold_before_edge", outs, M_ADD | M_REG_LD);
        step(1'b0, 3'd4);
        chk("exec_abort", outs, E_RESET);

        // Opcode sweep, opcode scrambled outside EXECUTE.
        step(1'b0, 3'd0);
        for (int op = 0; op < 8; op++) begin
            step(1'b1, 3'($urandom_range(0, 7)));
            chk($sformatf("sweep_fetch%0d", op), outs, E_FETCH);
            step(1'b1, 3'($urandom_range(0, 7)));
            chk($sformatf("sweep_decode%0d", op), outs, E_DECODE);
            step(1'b1, 3'(op));
            chk($sformatf("sweep_exec%0d", op), outs, model_exp(since, 3'(op)));
        end

        // Randomized run with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 19) != 0);
            r_opc = 3'($urandom_range(0, 7));
            step(r_rst, r_opc);
            chk($sformatf("rand%0d", i), outs, model_exp(since, r_opc));
            checks++;
            if ($countones({Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass}) > 1 ||
                (Ram_Data_Read && Ram_Data_Write) || (PC_Inc && PC_Load)) begin
                failures++;
                $display("FAIL invariant%0d: got %b expected exclusive strobes", i, outs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
